// File: rtl/hmr_pkg.sv
// Shared types for the TMR rapid-recovery sequencer: FSM states and the
// per-state control word that drives the registered handshake outputs.
package hmr_pkg;

  localparam int unsigned RecoveryTimeoutDefault = 255;

  typedef enum logic [2:0] {
    RR_IDLE,
    RR_HALT,
    RR_RF_RESTORE,
    RR_PC_RESTORE,
    RR_RESUME,
    RR_DONE,
    RR_FAIL
  } rapid_rec_state_e;

  typedef struct packed {
    logic       busy;
    logic       freeze;
    logic [2:0] halt;
    logic [2:0] resume;
    logic       pc_we;
    logic       finished;
    logic       failed;
  } rr_ctrl_t;

  // Control word for the state being entered; registered by the FSM so every
  // handshake output comes straight from a flop.
  function automatic rr_ctrl_t rr_decode(rapid_rec_state_e s);
    rr_ctrl_t c;
    c        = '0;
    c.busy   = (s != RR_IDLE);
    c.freeze = (s != RR_IDLE);
    case (s)
      RR_HALT, RR_RF_RESTORE: c.halt = 3'b111;
      RR_PC_RESTORE: begin
        c.halt  = 3'b111;
        c.pc_we = 1'b1;
      end
      RR_RESUME: c.resume   = 3'b111;
      RR_DONE:   c.finished = 1'b1;
      RR_FAIL:   c.failed   = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hmr_rr_timeout_cnt.sv
// Acknowledge timeout counter shared by the halt and resume waits.
// expired is high on the enabled cycle whose increment reaches Timeout.
module hmr_rr_timeout_cnt #(
  parameter int unsigned Timeout = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntWidth = (Timeout < 1) ? 1 : $clog2(Timeout + 1);
  localparam logic [CntWidth-1:0] LastCount = CntWidth'(Timeout - 1);

  logic [CntWidth-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CntWidth'(1);
    end
  end

  assign expired = enable && (count == LastCount);

endmodule

// File: rtl/hmr_tmr_rapid_recovery_seq.sv
// Rapid-recovery sequencer: halts all three cores, replays the backup RF and
// PC into them, resumes them in lockstep and reports done or failed.
module hmr_tmr_rapid_recovery_seq
  import hmr_pkg::*;
#(
  parameter int unsigned NumRfRegs   = 32,
  parameter int unsigned RfAddrWidth = 5,
  parameter int unsigned DataWidth   = 32,
  parameter bit          SkipReg0    = 1'b1,
  parameter int unsigned Timeout     = RecoveryTimeoutDefault
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   recovery_request_i,
  output logic                   recovery_finished_o,
  output logic                   recovery_failed_o,
  output logic                   busy_o,
  output logic                   backup_freeze_o,
  output logic [2:0]             debug_halt_o,
  input  logic [2:0]             core_halted_i,
  output logic [2:0]             debug_resume_o,
  output logic [RfAddrWidth-1:0] backup_raddr_o,
  input  logic [DataWidth-1:0]   backup_rdata_i,
  input  logic [DataWidth-1:0]   backup_pc_i,
  output logic                   rf_we_o,
  output logic [RfAddrWidth-1:0] rf_waddr_o,
  output logic [DataWidth-1:0]   rf_wdata_o,
  output logic                   pc_we_o,
  output logic [DataWidth-1:0]   pc_o
);

  localparam logic [RfAddrWidth-1:0] FirstAddr = SkipReg0 ? RfAddrWidth'(1) : '0;
  localparam logic [RfAddrWidth-1:0] LastAddr  = RfAddrWidth'(NumRfRegs - 1);

  rapid_rec_state_e       state_q, state_d;
  rr_ctrl_t               ctrl_q;
  logic                   rearm_q;
  logic                   rd_done_q;
  logic                   rf_we_q;
  logic [RfAddrWidth-1:0] rd_cnt_q;
  logic [RfAddrWidth-1:0] rf_waddr_q;
  logic                   all_halted, all_running;
  logic                   to_clear, to_enable, to_expired;

  assign all_halted  = (core_halted_i == 3'b111);
  assign all_running = (core_halted_i == 3'b000);

  // A dropped request is ignored once HALT is entered so the cores are never
  // left stopped with a half-restored register file.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RR_IDLE:       if (recovery_request_i && rearm_q) state_d = RR_HALT;
      RR_HALT: begin
        if (all_halted)      state_d = RR_RF_RESTORE;
        else if (to_expired) state_d = RR_FAIL;
      end
      RR_RF_RESTORE: if (rd_done_q) state_d = RR_PC_RESTORE;
      RR_PC_RESTORE: state_d = RR_RESUME;
      RR_RESUME: begin
        if (all_running)     state_d = RR_DONE;
        else if (to_expired) state_d = RR_FAIL;
      end
      RR_DONE:       state_d = RR_IDLE;
      RR_FAIL:       if (!recovery_request_i) state_d = RR_IDLE;
      default:       state_d = RR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RR_IDLE;
      ctrl_q     <= '0;
      rearm_q    <= 1'b1;
      rd_cnt_q   <= '0;
      rd_done_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= rr_decode(state_d);

      if (!recovery_request_i) begin
        rearm_q <= 1'b1;
      end else if (state_q == RR_IDLE && state_d == RR_HALT) begin
        rearm_q <= 1'b0;
      end

      // Backup read data arrives one cycle after the address, so the write
      // address is the read address delayed by one register.
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      if (state_q == RR_RF_RESTORE && !rd_done_q) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= rd_cnt_q;
        if (rd_cnt_q == LastAddr) rd_done_q <= 1'b1;
        else                      rd_cnt_q  <= rd_cnt_q + RfAddrWidth'(1);
      end

      if (state_d == RR_RF_RESTORE && state_q != RR_RF_RESTORE) begin
        rd_cnt_q  <= FirstAddr;
        rd_done_q <= 1'b0;
      end else if (state_d != RR_RF_RESTORE) begin
        rd_cnt_q  <= '0;
        rd_done_q <= 1'b0;
      end
    end
  end

  assign to_clear  = !(state_q == RR_HALT || state_q == RR_RESUME);
  assign to_enable = (state_q == RR_HALT && !all_halted) ||
                     (state_q == RR_RESUME && !all_running);

  hmr_rr_timeout_cnt #(
    .Timeout(Timeout)
  ) u_timeout (
    .clk    (clk_i),
    .rst    (rst_i),
    .clear  (to_clear),
    .enable (to_enable),
    .expired(to_expired)
  );

  assign recovery_finished_o = ctrl_q.finished;
  assign recovery_failed_o   = ctrl_q.failed;
  assign busy_o              = ctrl_q.busy;
  assign backup_freeze_o     = ctrl_q.freeze;
  assign debug_halt_o        = ctrl_q.halt;
  assign debug_resume_o      = ctrl_q.resume;
  assign backup_raddr_o      = rd_cnt_q;
  assign rf_we_o             = rf_we_q;
  assign rf_waddr_o          = rf_waddr_q;
  assign rf_wdata_o          = rf_we_q ? backup_rdata_i : '0;
  assign pc_we_o             = ctrl_q.pc_we;
  assign pc_o                = ctrl_q.pc_we ? backup_pc_i : '0;

endmodule

// File: tb/tb_hmr_tmr_rapid_recovery_seq.sv
// Directed bench for the rapid-recovery sequencer: table of per-cycle control
// expectations plus hand sequences for timeout, reset and request corner cases.
module tb_hmr_tmr_rapid_recovery_seq;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int W  = AW + DW;
  localparam logic [DW-1:0] PcVal0 = 32'h1C00_0080;
  localparam logic [DW-1:0] PcVal1 = 32'h1C00_0100;

  // clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          req0, fin0, failed0, busy0, frz0, rf_we0, pc_we0, auto0;
  logic [2:0]    halt0, resume0, halted0, force0;
  logic [AW-1:0] raddr0, waddr0;
  logic [DW-1:0] rdata0, wdata0, pc0;

  logic          req1, fin1, failed1, busy1, frz1, rf_we1, pc_we1;
  logic [2:0]    halt1, resume1, halted1;
  logic [AW-1:0] raddr1, waddr1;
  logic [DW-1:0] rdata1, wdata1, pc1;

  assign halted0 = auto0 ? halt0 : force0;
  assign halted1 = halt1;

  always @(posedge clk) rdata0 <= DW'(raddr0) * 3;
  always @(posedge clk) rdata1 <= DW'(raddr1) * 3 + 5;

  hmr_tmr_rapid_recovery_seq dut0 (
    .clk_i(clk), .rst_i(rst), .recovery_request_i(req0),
    .recovery_finished_o(fin0), .recovery_failed_o(failed0), .busy_o(busy0),
    .backup_freeze_o(frz0), .debug_halt_o(halt0), .core_halted_i(halted0),
    .debug_resume_o(resume0), .backup_raddr_o(raddr0), .backup_rdata_i(rdata0),
    .backup_pc_i(PcVal0), .rf_we_o(rf_we0), .rf_waddr_o(waddr0),
    .rf_wdata_o(wdata0), .pc_we_o(pc_we0), .pc_o(pc0)
  );

  hmr_tmr_rapid_recovery_seq #(.SkipReg0(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .recovery_request_i(req1),
    .recovery_finished_o(fin1), .recovery_failed_o(failed1), .busy_o(busy1),
    .backup_freeze_o(frz1), .debug_halt_o(halt1), .core_halted_i(halted1),
    .debug_resume_o(resume1), .backup_raddr_o(raddr1), .backup_rdata_i(rdata1),
    .backup_pc_i(PcVal1), .rf_we_o(rf_we1), .rf_waddr_o(waddr1),
    .rf_wdata_o(wdata1), .pc_we_o(pc_we1), .pc_o(pc1)
  );

  int checks = 0;
  int errors = 0;
  int pc_cnt0 = 0;
  int pc_cnt1 = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] e0, e1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ev(input logic b, input logic f, input logic [2:0] h,
                                     input logic [2:0] r, input logic we, input logic pw,
                                     input logic fi, input logic fa);
    return {b, f, h, r, we, pw, fi, fa};
  endfunction

  function automatic logic [11:0] obs0();
    return {busy0, frz0, halt0, resume0, rf_we0, pc_we0, fin0, failed0};
  endfunction

  function automatic logic [11:0] obs1();
    return {busy1, frz1, halt1, resume1, rf_we1, pc_we1, fin1, failed1};
  endfunction

  // scoreboard: every RF write and PC write is checked as it appears
  always @(negedge clk) begin
    if (rf_we0) begin
      checks++;
      if (exp_q0.size() == 0) begin
        errors++;
        $display("FAIL wr0_unexpected: got addr %0d data %0d, required no write", waddr0, wdata0);
      end else begin
        e0 = exp_q0.pop_front();
        if ({waddr0, wdata0} !== e0) begin
          errors++;
          $display("FAIL wr0: got addr %0d data %0d, required addr %0d data %0d",
                   waddr0, wdata0, e0[W-1:DW], e0[DW-1:0]);
        end
      end
    end
    if (pc_we0) begin
      pc_cnt0++;
      checks++;
      if (pc0 !== PcVal0) begin
        errors++;
        $display("FAIL pc0: got %0h, required %0h", pc0, PcVal0);
      end
    end
    if (rf_we1) begin
      checks++;
      if (exp_q1.size() == 0) begin
        errors++;
        $display("FAIL wr1_unexpected: got addr %0d data %0d, required no write", waddr1, wdata1);
      end else begin
        e1 = exp_q1.pop_front();
        if ({waddr1, wdata1} !== e1) begin
          errors++;
          $display("FAIL wr1: got addr %0d data %0d, required addr %0d data %0d",
                   waddr1, wdata1, e1[W-1:DW], e1[DW-1:0]);
        end
      end
    end
    if (pc_we1) begin
      pc_cnt1++;
      checks++;
      if (pc1 !== PcVal1) begin
        errors++;
        $display("FAIL pc1: got %0h, required %0h", pc1, PcVal1);
      end
    end
  end

  typedef struct {
    int         cyc;
    logic       req;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[14];
  int   ti;
  int   found;
  int   fin_cnt, fin_cyc;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    // Cycle n = n clock edges after the request is first seen high.
    tbl[0]  = '{0,  1'b1, ev(0, 0, 3'd0, 3'd0, 0, 0, 0, 0)};
    tbl[1]  = '{1,  1'b1, ev(1, 1, 3'd7, 3'd0, 0, 0, 0, 0)};
    tbl[2]  = '{2,  1'b1, ev(1, 1, 3'd7, 3'd0, 0, 0, 0, 0)};
    tbl[3]  = '{3,  1'b1, ev(1, 1, 3'd7, 3'd0, 1, 0, 0, 0)};
    tbl[4]  = '{33, 1'b1, ev(1, 1, 3'd7, 3'd0, 1, 0, 0, 0)};
    tbl[5]  = '{34, 1'b1, ev(1, 1, 3'd7, 3'd0, 0, 1, 0, 0)};
    tbl[6]  = '{35, 1'b1, ev(1, 1, 3'd0, 3'd7, 0, 0, 0, 0)};
    tbl[7]  = '{36, 1'b1, ev(1, 1, 3'd0, 3'd0, 0, 0, 1, 0)};
    tbl[8]  = '{37, 1'b1, ev(0, 0, 3'd0, 3'd0, 0, 0, 0, 0)};
    tbl[9]  = '{38, 1'b1, ev(0, 0, 3'd0, 3'd0, 0, 0, 0, 0)};
    tbl[10] = '{39, 1'b1, ev(0, 0, 3'd0, 3'd0, 0, 0, 0, 0)};
    tbl[11] = '{40, 1'b0, ev(0, 0, 3'd0, 3'd0, 0, 0, 0, 0)};
    tbl[12] = '{41, 1'b1, ev(0, 0, 3'd0, 3'd0, 0, 0, 0, 0)};
    tbl[13] = '{42, 1'b1, ev(1, 1, 3'd7, 3'd0, 0, 0, 0, 0)};

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; auto0 = 1'b1; force0 = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl0", obs0(), 12'h000);
    check("reset_ctrl1", obs1(), 12'h000);
    check("reset_data0", {raddr0, waddr0, wdata0, pc0}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_we", {rf_we0, rf_we1}, 2'b00);
    @(posedge clk); #1;

    // Immediate acks, then request held past done, then re-armed
    for (int i = 1; i < 32; i++) exp_q0.push_back({AW'(i), DW'(i * 3)});
    for (int i = 1; i < 10; i++) exp_q0.push_back({AW'(i), DW'(i * 3)});
    ti = 0;
    for (int n = 0; n <= 42; n++) begin
      if (ti < 14 && tbl[ti].cyc == n) req0 = tbl[ti].req;
      @(negedge clk);
      if (ti < 14 && tbl[ti].cyc == n) begin
        check($sformatf("vec_c%0d", n), obs0(), tbl[ti].exp);
        ti++;
      end
      @(posedge clk); #1;
    end
    check("seq1_writes_left", exp_q0.size(), 9);
    check("seq1_pc_count", pc_cnt0, 1);

    // Reset in the middle of RF restore while address 10 is being read
    found = 0;
    for (int n = 0; n < 40 && found == 0; n++) begin
      @(negedge clk);
      if (busy0 && raddr0 == AW'(10)) found = 1;
      else @(posedge clk);
    end
    check("rst_reach_addr10", found, 1);
    rst = 1'b1; req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_ctrl", obs0(), 12'h000);
    check("rst_mid_data", {raddr0, waddr0, wdata0, pc0}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("rst_stays_idle", busy0, 0);
    check("rst_no_more_writes", exp_q0.size(), 0);
    @(posedge clk); #1;

    // Partial halt ack stuck: timeout into FAIL, then release
    auto0 = 1'b0; force0 = 3'b011; req0 = 1'b1;
    for (int n = 1; n <= 258; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 255) check("to_halt_c255", obs0(), ev(1, 1, 3'd7, 3'd0, 0, 0, 0, 0));
      if (n == 256) check("to_fail_c256", obs0(), ev(1, 1, 3'd0, 3'd0, 0, 0, 0, 1));
      if (n == 258) check("fail_held_c258", obs0(), ev(1, 1, 3'd0, 3'd0, 0, 0, 0, 1));
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    check("fail_until_drop", failed0, 1);
    @(posedge clk); @(negedge clk);
    check("fail_cleared", obs0(), 12'h000);
    @(posedge clk); #1;

    // Request dropped during HALT, halt ack two cycles late
    for (int i = 1; i < 32; i++) exp_q0.push_back({AW'(i), DW'(i * 3)});
    force0 = 3'b000; req0 = 1'b1;
    fin_cnt = 0; fin_cyc = 0;
    for (int n = 1; n <= 70; n++) begin
      @(posedge clk); #1;
      if (n == 1) req0 = 1'b0;
      if (n == 3) auto0 = 1'b1;
      @(negedge clk);
      if (fin0) begin
        fin_cnt++;
        fin_cyc = n;
      end
    end
    check("drop_fin_count", fin_cnt, 1);
    check("drop_fin_cycle", fin_cyc, 38);
    check("drop_writes_left", exp_q0.size(), 0);
    check("drop_pc_count", pc_cnt0, 2);
    check("drop_idle", busy0, 0);
    @(posedge clk); #1;

    // Register 0 restored as well
    for (int i = 0; i < 32; i++) exp_q1.push_back({AW'(i), DW'(i * 3 + 5)});
    req1 = 1'b1;
    fin_cnt = 0; fin_cyc = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (fin_cnt > 0) req1 = 1'b0;
      @(negedge clk);
      if (fin1) begin
        fin_cnt++;
        fin_cyc = n;
      end
    end
    check("r0_fin_count", fin_cnt, 1);
    check("r0_fin_cycle", fin_cyc, 37);
    check("r0_writes_left", exp_q1.size(), 0);
    check("r0_pc_count", pc_cnt1, 1);
    check("r0_idle", obs1(), 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hmr_tmr_rapid_recovery_seq.md
Name: hmr_tmr_rapid_recovery_seq

Overview:
- Sequencer directly downstream of the TMR control unit's rapid-recovery handshake.
- Consumes recovery_request and returns recovery_finished.
- Between the two it halts all three cores, restores the register file from the last-good backup, restores the PC, and resumes the cores in lockstep.
- Sits between the TMR controller and the per-core debug/RF write-back paths; the backup storage lives outside this block.

Parameters:
NumRfRegs, 32, number of architectural registers restored
RfAddrWidth, 5, register address width, equal to $clog2(NumRfRegs)
DataWidth, 32, register and PC data width
SkipReg0, 1'b1, when 1, register 0 is never read or written (hardwired zero)
Timeout, 255, maximum cycles waiting for halt or resume acknowledge; counter width is $clog2(Timeout+1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
recovery_request_i  in  1  level request from TMR controller
recovery_finished_o  out  1  one-cycle done pulse to TMR controller
recovery_failed_o  out  1  sticky abort flag
busy_o  out  1  high in any state except IDLE
backup_freeze_o  out  1  stops backup RF/PC capture while high
debug_halt_o  out  3  halt request per core
core_halted_i  in  3  halted status per core
debug_resume_o  out  3  resume request per core
backup_raddr_o  out  RfAddrWidth  backup RF read address
backup_rdata_i  in  DataWidth  backup RF read data, valid one cycle after address
backup_pc_i  in  DataWidth  last-good PC
rf_we_o  out  1  broadcast RF write enable to all cores
rf_waddr_o  out  RfAddrWidth  broadcast write address
rf_wdata_o  out  DataWidth  broadcast write data
pc_we_o  out  1  broadcast PC write enable
pc_o  out  DataWidth  broadcast PC value

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - All outputs are 0.
  - The re-arm flag is 1.
  - All counters are 0.
- States: IDLE, HALT, RF_RESTORE, PC_RESTORE, RESUME, DONE, FAIL.
- IDLE:
  - Accepts the request when recovery_request_i=1 and re-arm=1; moves to HALT next cycle and clears re-arm.
  - Re-arm is set again on any cycle where recovery_request_i=0.
- HALT:
  - debug_halt_o=3'b111, backup_freeze_o=1.
  - If core_halted_i==3'b111, go to RF_RESTORE.
  - Else increment the timeout counter; when the count reaches Timeout, go to FAIL.
- RF_RESTORE:
  - debug_halt_o stays 3'b111.
  - Read counter starts at 1 when SkipReg0=1, else 0, and issues one address per cycle up to NumRfRegs-1.
  - Write pipeline register: on the cycle after each read, rf_we_o=1, rf_waddr_o is the address delayed by one cycle, rf_wdata_o=backup_rdata_i.
  - Go to PC_RESTORE in the cycle the last write is issued. Total writes = NumRfRegs-SkipReg0.
- PC_RESTORE:
  - Single cycle: pc_we_o=1, pc_o=backup_pc_i.
  - Go to RESUME; the timeout counter is cleared.
- RESUME:
  - debug_halt_o=0, debug_resume_o=3'b111.
  - When core_halted_i==3'b000, go to DONE.
  - Timeout to FAIL, as in HALT.
- DONE:
  - recovery_finished_o=1 for exactly one cycle, then IDLE.
  - backup_freeze_o drops on entry to IDLE.
- FAIL:
  - recovery_failed_o=1, all halt/resume/write outputs 0, backup_freeze_o=1.
  - Stays in FAIL until recovery_request_i=0, then IDLE. recovery_failed_o clears on the same edge.
- recovery_request_i deasserting mid-sequence (HALT..RESUME) is ignored; the sequence runs to DONE so cores are never left halted with a partial RF.
- rst_i mid-sequence returns immediately to IDLE with all outputs 0. rf_we_o is never asserted on the cycle after reset.
- Partial halt acknowledge (for example 3'b101) counts as not halted.
- A core de-asserting halted during RF_RESTORE is not re-checked; the restore proceeds.
- Minimum latency from accepted request to recovery_finished_o: 1 (HALT) + (NumRfRegs-SkipReg0+1) + 1 + 1 + 1 cycles, with immediate acknowledges. For defaults this is 36 cycles.

Decomposition:
- hmr_pkg holds:
  - the state enum rapid_rec_state_e;
  - the localparam RecoveryTimeoutDefault=255.
- One sub-module, hmr_rr_timeout_cnt: clear, enable, expired outputs, width from Timeout. It is instantiated once and shared by HALT and RESUME.

Test Plan:
1. Immediate acknowledges, backup RF[i]=i*3, backup PC=32'h1C00_0080 -> rf_we_o pulses 31 times with addresses 1..31 and data 3..93; pc_we_o once with 1C00_0080; recovery_finished_o on cycle 36 after the request.
2. SkipReg0=0 -> 32 writes, address 0 written first with backup_rdata for address 0; finished on cycle 37.
3. core_halted_i stuck at 3'b011 -> FAIL after 255 cycles in HALT; recovery_failed_o=1 and no rf_we_o. After the request drops: IDLE, failed cleared.
4. Request held high for 3 cycles after the finished pulse -> no second sequence. The request drops for 1 cycle, then rises -> a new sequence starts.
5. rst_i asserted while in RF_RESTORE at address 10 -> next cycle IDLE, all outputs 0, no further writes.
6. Request drops during HALT, halted=3'b111 two cycles later -> the full restore still completes and recovery_finished_o pulses once.
